// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : next-PC source select, PC register and call/return stack
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
   parameter int                 d_width      = 12,
   parameter int                 stack_depth  = 8,
   parameter int                 sp_width     = 4,
   parameter logic [d_width-1:0] reset_vector = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic [2:0]          op,
   input  logic                cond,
   input  logic [d_width-1:0]  target,
   input  logic [d_width-1:0]  next_pc,
   output logic [d_width-1:0]  pc,
   output logic [d_width-1:0]  pc_inc,
   output logic [d_width-1:0]  ret_addr,
   output logic [1:0]          mux_sel,
   output logic [sp_width-1:0] sp,
   output logic                stk_ovf,
   output logic                stk_unf
);

   localparam logic [2:0] c_op_jump  = 3'b001;
   localparam logic [2:0] c_op_jumpc = 3'b010;
   localparam logic [2:0] c_op_call  = 3'b011;
   localparam logic [2:0] c_op_ret   = 3'b100;

   localparam logic [1:0] c_sel_inc    = 2'b00;
   localparam logic [1:0] c_sel_target = 2'b01;
   localparam logic [1:0] c_sel_ret    = 2'b10;

   localparam logic [sp_width-1:0] c_sp_full = sp_width'(stack_depth);
   localparam logic [sp_width-1:0] c_sp_one  = sp_width'(1);

   logic [d_width-1:0]  r_pc;
   logic [sp_width-1:0] r_sp;
   logic                r_ovf;
   logic                r_unf;
   logic [d_width-1:0]  r_stack [stack_depth];

   logic                w_empty;
   logic                w_full;
   logic                w_is_call;
   logic                w_is_ret;
   logic                w_push;
   logic                w_pop;
   logic [d_width-1:0]  w_ret_addr;

   assign w_empty   = (r_sp == '0);
   assign w_full    = (r_sp == c_sp_full);
   assign w_is_call = ce && (op == c_op_call);
   assign w_is_ret  = ce && (op == c_op_ret);
   assign w_push    = w_is_call && !w_full;
   assign w_pop     = w_is_ret && !w_empty;

   always_comb begin
      mux_sel = c_sel_inc;
      case (op)
         c_op_jump:  mux_sel = c_sel_target;
         c_op_jumpc: mux_sel = cond ? c_sel_target : c_sel_inc;
         c_op_call:  mux_sel = c_sel_target;
         c_op_ret:   mux_sel = w_empty ? c_sel_inc : c_sel_ret;
         default:    mux_sel = c_sel_inc;
      endcase
   end

   // Top-of-stack read; an empty stack presents zero on the return input.
   always_comb begin
      w_ret_addr = '0;
      for (int i = 0; i < stack_depth; i++) begin
         if (r_sp == sp_width'(i + 1)) begin
            w_ret_addr = r_stack[i];
         end
      end
   end

   // Storage is not reset; gating on rst keeps a push aborted by reset out.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         for (int i = 0; i < stack_depth; i++) begin
            if (r_sp == sp_width'(i)) begin
               r_stack[i] <= pc_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= reset_vector;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (ce) begin
         r_pc <= next_pc;
         if (w_push) begin
            r_sp <= r_sp + c_sp_one;
         end else if (w_pop) begin
            r_sp <= r_sp - c_sp_one;
         end
         if (w_is_call && w_full) begin
            r_ovf <= 1'b1;
         end
         if (w_is_ret && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   assign pc       = r_pc;
   assign pc_inc   = r_pc + d_width'(1);
   assign ret_addr = w_ret_addr;
   assign sp       = r_sp;
   assign stk_ovf  = r_ovf;
   assign stk_unf  = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

   localparam logic [2:0] c_next  = 3'b000;
   localparam logic [2:0] c_jump  = 3'b001;
   localparam logic [2:0] c_jumpc = 3'b010;
   localparam logic [2:0] c_call  = 3'b011;
   localparam logic [2:0] c_ret   = 3'b100;

   logic        clk;
   logic        rst;
   logic        ce;
   logic [2:0]  op;
   logic        cond;
   logic [11:0] target;
   logic [11:0] next_pc;
   logic [11:0] pc;
   logic [11:0] pc_inc;
   logic [11:0] ret_addr;
   logic [1:0]  mux_sel;
   logic [3:0]  sp;
   logic        stk_ovf;
   logic        stk_unf;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(
      .d_width      (12),
      .stack_depth  (8),
      .sp_width     (4),
      .reset_vector (12'h000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .op       (op),
      .cond     (cond),
      .target   (target),
      .next_pc  (next_pc),
      .pc       (pc),
      .pc_inc   (pc_inc),
      .ret_addr (ret_addr),
      .mux_sel  (mux_sel),
      .sp       (sp),
      .stk_ovf  (stk_ovf),
      .stk_unf  (stk_unf)
   );

   // External 3-input address mux of the fetch path.
   always_comb begin
      case (mux_sel)
         2'b01:   next_pc = target;
         2'b10:   next_pc = ret_addr;
         default: next_pc = pc_inc;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic c, input logic [11:0] t, input logic e);
      op = o; cond = c; target = t; ce = e;
   endtask

   task automatic test_reset;
      rst = 1'b0; ce = 1'b0; op = c_next; cond = 1'b0; target = '0;
      #1 rst = 1'b1;
      #1;
      checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 12'h000); end
      checks++; if (sp !== 4'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", sp); end
      checks++; if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", stk_ovf, stk_unf); end
      checks++; if (pc_inc !== 12'h001) begin errors++; $display("FAIL reset_pc_inc: got %h want 001", pc_inc); end
      checks++; if (ret_addr !== 12'h000) begin errors++; $display("FAIL reset_ret_addr: got %h want 000", ret_addr); end
      tick();
      checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_hold_pc: got %h want 000", pc); end
      rst = 1'b0;
   endtask

   task automatic test_sequential;
      drive(c_next, 1'b0, 12'h000, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         checks++; if (mux_sel !== 2'b00) begin errors++; $display("FAIL seq_sel[%0d]: got %b want 00", i, mux_sel); end
         tick();
         checks++; if (pc !== 12'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 12'(i)); end
      end
   endtask

   task automatic test_wrap;
      drive(c_jump, 1'b0, 12'hFFF, 1'b1);
      checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL wrap_jump_sel: got %b want 01", mux_sel); end
      tick();
      checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_jump_pc: got %h want fff", pc); end
      checks++; if (pc_inc !== 12'h000) begin errors++; $display("FAIL wrap_pc_inc_top: got %h want 000", pc_inc); end
      drive(c_next, 1'b0, 12'h000, 1'b1);
      tick();
      checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got %h want 000", pc); end
      checks++; if (pc_inc !== 12'h001) begin errors++; $display("FAIL wrap_pc_inc: got %h want 001", pc_inc); end
   endtask

   task automatic test_call_ret;
      drive(c_jump, 1'b0, 12'h010, 1'b1);
      tick();
      drive(c_call, 1'b0, 12'h200, 1'b1);
      checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL call_sel: got %b want 01", mux_sel); end
      tick();
      checks++; if (pc !== 12'h200) begin errors++; $display("FAIL call_pc: got %h want 200", pc); end
      checks++; if (sp !== 4'd1) begin errors++; $display("FAIL call_sp: got %0d want 1", sp); end
      checks++; if (ret_addr !== 12'h011) begin errors++; $display("FAIL call_ret_addr: got %h want 011", ret_addr); end
      drive(c_ret, 1'b0, 12'h000, 1'b1);
      checks++; if (mux_sel !== 2'b10) begin errors++; $display("FAIL ret_sel: got %b want 10", mux_sel); end
      tick();
      checks++; if (pc !== 12'h011) begin errors++; $display("FAIL ret_pc: got %h want 011", pc); end
      checks++; if (sp !== 4'd0) begin errors++; $display("FAIL ret_sp: got %0d want 0", sp); end
   endtask

   // From pc=0x011: CALL k targets 0x100+16k, so entry 0 holds 0x012 and
   // entry e>0 holds 0x101+16(e-1).
   task automatic test_overflow;
      logic [11:0] exp_pc;
      for (int k = 0; k <= 8; k++) begin
         drive(c_call, 1'b0, 12'h100 + 12'(k * 16), 1'b1);
         if (k == 8) begin
            checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL ovf_sel: got %b want 01", mux_sel); end
         end
         tick();
      end
      checks++; if (sp !== 4'd8) begin errors++; $display("FAIL ovf_sp: got %0d want 8", sp); end
      checks++; if (stk_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", stk_ovf); end
      checks++; if (pc !== 12'h180) begin errors++; $display("FAIL ovf_pc: got %h want 180", pc); end
      checks++; if (ret_addr !== 12'h161) begin errors++; $display("FAIL ovf_ret_addr: got %h want 161", ret_addr); end
      checks++; if (stk_unf !== 1'b0) begin errors++; $display("FAIL ovf_unf: got %b want 0", stk_unf); end
      for (int r = 0; r < 8; r++) begin
         exp_pc = (r == 7) ? 12'h012 : 12'h101 + 12'((6 - r) * 16);
         drive(c_ret, 1'b0, 12'h000, 1'b1);
         checks++; if (mux_sel !== 2'b10) begin errors++; $display("FAIL unwind_sel[%0d]: got %b want 10", r, mux_sel); end
         tick();
         checks++; if (pc !== exp_pc) begin errors++; $display("FAIL unwind_pc[%0d]: got %h want %h", r, pc, exp_pc); end
         checks++; if (sp !== 4'(7 - r)) begin errors++; $display("FAIL unwind_sp[%0d]: got %0d want %0d", r, sp, 7 - r); end
      end
      drive(c_ret, 1'b0, 12'h000, 1'b1);
      checks++; if (mux_sel !== 2'b00) begin errors++; $display("FAIL unf_sel: got %b want 00", mux_sel); end
      tick();
      checks++; if (pc !== 12'h013) begin errors++; $display("FAIL unf_pc: got %h want 013", pc); end
      checks++; if (stk_unf !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", stk_unf); end
      checks++; if (sp !== 4'd0) begin errors++; $display("FAIL unf_sp: got %0d want 0", sp); end
      checks++; if (stk_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", stk_ovf); end
      checks++; if (ret_addr !== 12'h000) begin errors++; $display("FAIL unf_ret_addr: got %h want 000", ret_addr); end
   endtask

   task automatic test_jumpc;
      drive(c_jumpc, 1'b0, 12'h080, 1'b1);
      checks++; if (mux_sel !== 2'b00) begin errors++; $display("FAIL jumpc0_sel: got %b want 00", mux_sel); end
      tick();
      checks++; if (pc !== 12'h014) begin errors++; $display("FAIL jumpc0_pc: got %h want 014", pc); end
      drive(c_jumpc, 1'b1, 12'h080, 1'b1);
      checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL jumpc1_sel: got %b want 01", mux_sel); end
      tick();
      checks++; if (pc !== 12'h080) begin errors++; $display("FAIL jumpc1_pc: got %h want 080", pc); end
   endtask

   task automatic test_stall;
      drive(c_call, 1'b0, 12'h300, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL stall_sel[%0d]: got %b want 01", i, mux_sel); end
         tick();
         checks++; if (pc !== 12'h080 || sp !== 4'd0) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h sp=%0d want 080 0", i, pc, sp); end
      end
      ce = 1'b1;
      tick();
      checks++; if (pc !== 12'h300 || sp !== 4'd1) begin errors++; $display("FAIL stall_commit: got pc=%h sp=%0d want 300 1", pc, sp); end
      checks++; if (ret_addr !== 12'h081) begin errors++; $display("FAIL stall_ret_addr: got %h want 081", ret_addr); end
   endtask

   task automatic test_back_to_back;
      drive(c_ret, 1'b0, 12'h000, 1'b1);
      tick();
      checks++; if (pc !== 12'h081 || sp !== 4'd0) begin errors++; $display("FAIL b2b_ret: got pc=%h sp=%0d want 081 0", pc, sp); end
      drive(c_call, 1'b0, 12'h3A0, 1'b1);
      tick();
      drive(c_ret, 1'b0, 12'h000, 1'b1);
      tick();
      checks++; if (pc !== 12'h082 || sp !== 4'd0) begin errors++; $display("FAIL b2b_call_ret: got pc=%h sp=%0d want 082 0", pc, sp); end
   endtask

   task automatic test_reset_mid_call;
      drive(c_call, 1'b0, 12'h400, 1'b1); tick();
      drive(c_call, 1'b0, 12'h410, 1'b1); tick();
      drive(c_call, 1'b0, 12'h420, 1'b1); tick();
      checks++; if (sp !== 4'd3 || ret_addr !== 12'h411) begin errors++; $display("FAIL mid_setup: got sp=%0d ret=%h want 3 411", sp, ret_addr); end
      drive(c_call, 1'b0, 12'h500, 1'b1);
      #2 rst = 1'b1;
      #1;
      checks++; if (pc !== 12'h000 || sp !== 4'd0) begin errors++; $display("FAIL mid_async: got pc=%h sp=%0d want 000 0", pc, sp); end
      checks++; if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin errors++; $display("FAIL mid_flags: got ovf=%b unf=%b want 0 0", stk_ovf, stk_unf); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(c_next, 1'b0, 12'h000, 1'b0);
      #1;
      checks++; if (pc !== 12'h000 || sp !== 4'd0 || ret_addr !== 12'h000) begin errors++; $display("FAIL mid_release: got pc=%h sp=%0d ret=%h want 000 0 000", pc, sp, ret_addr); end
      drive(c_call, 1'b0, 12'h600, 1'b1);
      tick();
      checks++; if (pc !== 12'h600 || sp !== 4'd1) begin errors++; $display("FAIL mid_call: got pc=%h sp=%0d want 600 1", pc, sp); end
      checks++; if (ret_addr !== 12'h001) begin errors++; $display("FAIL mid_ret_addr: got %h want 001", ret_addr); end
      drive(c_ret, 1'b0, 12'h000, 1'b1);
      tick();
      checks++; if (pc !== 12'h001 || sp !== 4'd0) begin errors++; $display("FAIL mid_ret: got pc=%h sp=%0d want 001 0", pc, sp); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_call_ret();
      test_overflow();
      test_jumpc();
      test_stall();
      test_back_to_back();
      test_reset_mid_call();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
